systolic_obi_copy_engine: RTL and testbench

OBI initiator that copies a block of 32-bit words from a source address range to a destination address range, one transaction at a time. It sits beside the systolic array wrapper on the system bus as a master port. It loads operand and weight words from SRAM into the array's memory-mapped window, or drains results back, without CPU load/store loops. The engine supports one outstanding OBI transaction; each word costs one read followed by one write.

---
 rtl/heepstor_pkg.sv | 17 +
 rtl/obi_pkg.sv | 20 ++
 rtl/systolic_obi_copy_engine.sv | 147 ++++++++++++++
 tb/tb_systolic_obi_copy_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/heepstor_pkg.sv
// Shared definitions for the heepstor systolic subsystem.
//   copy_state_e    : copy engine FSM states
//   COPY_WORD_BYTES : byte stride between consecutive copied words
package heepstor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } copy_state_e;

  localparam int unsigned COPY_WORD_BYTES = 4;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by bus initiators and responders.
//   obi_req_t  : req, we, be, addr, wdata (initiator -> responder)
//   obi_resp_t : gnt, rvalid, rdata       (responder -> initiator)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/systolic_obi_copy_engine.sv
// OBI initiator copying len_i 32-bit words from src_addr_i to dst_addr_i,
// one outstanding transaction at a time (read word, then write it).
// Optional feature macro: HEEPSTOR_COPY_CHECKSUM_EN (running sum of copied
// words on checksum_o; tied to zero when undefined).
// Ports:
//   clk_i, rst_n        clock, synchronous active-low reset
//   start_i             launch a copy (honoured only in IDLE)
//   src_addr_i          source byte address (low 2 bits ignored)
//   dst_addr_i          destination byte address (low 2 bits ignored)
//   len_i               word count
//   busy_o              transfer in progress
//   done_o              one-cycle completion pulse
//   checksum_o          sum of copied words (feature-dependent)
//   obi_master_req_o    OBI request channel
//   obi_master_resp_i   OBI response channel
module systolic_obi_copy_engine
  import heepstor_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      checksum_o,
  output obi_req_t         obi_master_req_o,
  input  obi_resp_t        obi_master_resp_i
);

  copy_state_e      state_d, state_q;
  logic [31:0]      src_d, src_q;
  logic [31:0]      dst_d, dst_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic [LEN_W-1:0] cnt_d, cnt_q;
  logic [31:0]      data_d, data_q;
  logic [31:0]      offset;
  logic [LEN_W-1:0] cnt_inc;

  // Byte offset of the current word; 32-bit addition below wraps naturally.
  assign offset  = 32'(cnt_q) * 32'(COPY_WORD_BYTES);
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Request fields depend only on registered state, so a stalled request
  // holds addr/we/be/wdata until granted and resp never reaches req combinationally.
  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    obi_master_req_o = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            src_d   = {src_addr_i[31:2], 2'b00};
            dst_d   = {dst_addr_i[31:2], 2'b00};
            len_d   = len_i;
            cnt_d   = '0;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_REQ: begin
        obi_master_req_o.req  = 1'b1;
        obi_master_req_o.be   = 4'hF;
        obi_master_req_o.addr = src_q + offset;
        if (obi_master_resp_i.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (obi_master_resp_i.rvalid) begin
          data_d  = obi_master_resp_i.rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        obi_master_req_o.req   = 1'b1;
        obi_master_req_o.we    = 1'b1;
        obi_master_req_o.be    = 4'hF;
        obi_master_req_o.addr  = dst_q + offset;
        obi_master_req_o.wdata = data_q;
        if (obi_master_resp_i.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (obi_master_resp_i.rvalid) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                  (state_q == WR_REQ) || (state_q == WR_WAIT);
  assign done_o = (state_q == DONE);

`ifdef HEEPSTOR_COPY_CHECKSUM_EN
  logic [31:0] checksum_d, checksum_q;

  // Cleared on any accepted start (including zero length), held after DONE.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start_i)
      checksum_d = '0;
    else if (state_q == RD_WAIT && obi_master_resp_i.rvalid)
      checksum_d = checksum_q + obi_master_resp_i.rdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_systolic_obi_copy_engine.sv
// Self-checking bench for systolic_obi_copy_engine: a memory responder with
// same-cycle grant (optionally stalled on the first write) and rvalid one
// cycle after grant, plus a scoreboard of expected bus transactions.
module tb_systolic_obi_copy_engine;
  import obi_pkg::*;

  localparam int LEN_W = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      src_addr_i = '0;
  logic [31:0]      dst_addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o;
  logic [31:0]      checksum_o;
  obi_req_t         req;
  obi_resp_t        resp;

  int checks = 0;
  int errors = 0;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  // responder state
  logic        gnt;
  logic        rvalid_q = 1'b0;
  logic [31:0] rdata_q = '0;
  int          stall_cycles = 0;
  int          stall_seen = 0;

  systolic_obi_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk_i             (clk_i),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .src_addr_i        (src_addr_i),
    .dst_addr_i        (dst_addr_i),
    .len_i             (len_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .checksum_o        (checksum_o),
    .obi_master_req_o  (req),
    .obi_master_resp_i (resp)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD0000 ^ a;
  endfunction

  // Grant is withheld on the first write of a copy for stall_cycles cycles.
  assign gnt         = req.req && !(req.we && (stall_seen < stall_cycles));
  assign resp.gnt    = gnt;
  assign resp.rvalid = rvalid_q;
  assign resp.rdata  = rdata_q;

  always @(posedge clk_i) begin
    rvalid_q <= rst_n && req.req && gnt;
    rdata_q  <= (req.req && gnt && !req.we) ? rd_word(req.addr) : 32'h0;
    if (start_i) stall_seen <= 0;
    else if (req.req && req.we && !gnt) stall_seen <= stall_seen + 1;
  end

  // Drive one copy and monitor every cycle against the scoreboard.
  // busy_cyc: cycle on which a stray start is pulsed (0 = none).
  // rst_cyc : cycle at whose end reset is applied (0 = none).
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input logic [31:0] base, input int stall,
                          input int busy_cyc, input int rst_cyc);
    int          exp_done, done_cnt, done_at, stalls, budget;
    bit          aborted;
    logic [31:0] sum, a;
    txn_t        t;
    sum = '0; done_cnt = 0; done_at = 0; stalls = 0; aborted = 0;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(i) * 32'd4;
      mem[a] = base + 32'(i);
      sum = sum + base + 32'(i);
      t.we = 1'b0; t.addr = a; t.wdata = '0;
      exp_q.push_back(t);
      t.we = 1'b1; t.addr = dst + 32'(i) * 32'd4; t.wdata = base + 32'(i);
      exp_q.push_back(t);
    end
    exp_done = 4 * len + 1 + stall;
    budget   = exp_done + 10;
    stall_cycles = stall;
    @(negedge clk_i);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(len);
    @(posedge clk_i);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        checks++;
        if (req !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || checksum_o !== 32'h0) begin
          errors++;
          $display("FAIL %s reset_mid: req=%h busy=%b done=%b csum=%h, want all 0",
                   name, req, busy_o, done_o, checksum_o);
        end
        rst_n = 1'b1;
        aborted = 1;
        exp_q.delete();
      end
      if (req.req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_txn cyc=%0d we=%b addr=%h, want none", name, cyc, req.we, req.addr);
        end else begin
          t = exp_q[0];
          if (req.we !== t.we || req.addr !== t.addr || req.be !== 4'hF ||
              (t.we && req.wdata !== t.wdata)) begin
            errors++;
            $display("FAIL %s txn cyc=%0d got we=%b addr=%h be=%h wdata=%h, want we=%b addr=%h wdata=%h",
                     name, cyc, req.we, req.addr, req.be, req.wdata, t.we, t.addr, t.wdata);
          end
          if (gnt) void'(exp_q.pop_front());
          else stalls++;
        end
      end
      if (len == 0) begin
        checks++;
        if (busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s zero_len_busy cyc=%0d busy=%b, want 0", name, cyc, busy_o);
        end
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_at = cyc;
      end
      if (cyc == busy_cyc) begin
        start_i = 1'b1; src_addr_i = 32'h5000; len_i = LEN_W'(7);
      end
      if (rst_cyc != 0 && cyc == rst_cyc) rst_n = 1'b0;
      if (!aborted && done_cnt > 0 && cyc >= done_at + 2) break;
    end
    if (aborted) begin
      checks++;
      if (done_cnt != 0) begin
        errors++;
        $display("FAIL %s done_after_reset count=%0d, want 0", name, done_cnt);
      end
    end else begin
      checks++;
      if (done_at != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle got k+%0d, want k+%0d", name, done_at, exp_done);
      end
      checks++;
      if (done_cnt != 1) begin
        errors++;
        $display("FAIL %s done_pulses got %0d, want 1", name, done_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s missing_txns got %0d left, want 0", name, exp_q.size());
      end
      checks++;
      if (stalls != stall) begin
        errors++;
        $display("FAIL %s stall_cycles got %0d, want %0d", name, stalls, stall);
      end
`ifdef HEEPSTOR_COPY_CHECKSUM_EN
      a = sum;
`else
      a = 32'h0;
`endif
      checks++;
      if (checksum_o !== a) begin
        errors++;
        $display("FAIL %s checksum got %h, want %h", name, checksum_o, a);
      end
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_after_done got %b, want 0", name, busy_o);
      end
    end
    exp_q.delete();
    stall_cycles = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (req !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || checksum_o !== 32'h0) begin
      errors++;
      $display("FAIL reset req=%h busy=%b done=%b csum=%h, want all 0", req, busy_o, done_o, checksum_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_copy();
    run_copy("basic", 32'h1000, 32'h2000, 3, 32'hA, 0, 0, 0);
  endtask

  task automatic test_zero_length();
    run_copy("zero_len", 32'h1000, 32'h2000, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_grant_stall();
    run_copy("grant_stall", 32'h1100, 32'h2100, 3, $urandom, 5, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_copy("start_busy", 32'h1200, 32'h2200, 4, $urandom, 0, 6, 0);
  endtask

  task automatic test_address_wrap();
    run_copy("addr_wrap", 32'hFFFF_FFFC, 32'h3000, 2, 32'h1234_5678, 0, 0, 0);
  endtask

  task automatic test_reset_mid_transfer();
    run_copy("reset_mid", 32'h1300, 32'h2300, 4, $urandom, 0, 0, 6);
    run_copy("after_reset", 32'h1400, 32'h2400, 2, $urandom, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_grant_stall();
    test_start_while_busy();
    test_address_wrap();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
